// File: rtl/keypad_scanner_pkg.sv
// Shared types for the keypad scanner: scan FSM encoding and event-width helpers.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_WAIT   = 2'd2
  } scan_state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int key_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // An event is {release, code}.
  function automatic int key_event_w(input int key_w);
    return key_w + 1;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key-event stream between the scanner (master) and its consumer (slave).
// An event transfers on a cycle where key_valid & key_ready; while key_valid=1 and
// key_ready=0 the master holds key_code/key_release stable, and key_valid never drops without a transfer.
interface keypad_if #(
  parameter int KEY_W = 4
) ();
  logic             key_valid;
  logic             key_ready;
  logic [KEY_W-1:0] key_code;
  logic             key_release;

  modport master (output key_valid, key_code, key_release, input key_ready);
  modport slave  (input key_valid, key_code, key_release, output key_ready);
endinterface

// File: rtl/keypad_scanner_sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through output; a pop frees a slot for a same-cycle push.
module sync_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column drive, row sync, per-key debounce, press/release events via FIFO.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int NUM_ROWS       = 4,
  parameter int NUM_COLS       = 4,
  parameter int SCAN_INTERVAL  = 100_000,
  parameter int SAMPLE_DELAY   = 5_000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_ROWS-1:0]          row,
  output logic [NUM_COLS-1:0]          col,
  keypad_if.master                     kif,
  output logic [NUM_ROWS*NUM_COLS-1:0] keys_down,
  output logic                         overflow,
  input  logic                         overflow_clr,
  output scan_state_e                  dbg_state
);
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;
  localparam int KEY_W    = key_width(NUM_KEYS);
  localparam int EV_W     = key_event_w(KEY_W);
  localparam int TW       = $clog2(SCAN_INTERVAL + 1);
  localparam int CW       = $clog2(DEBOUNCE_SCANS + 1);
  localparam int CIW      = key_width(NUM_COLS);
  localparam int RIW      = key_width(NUM_ROWS);

  logic [NUM_ROWS-1:0] row_s1_q, row_s2_q;
  logic [NUM_ROWS-1:0] row_capt_q, row_capt_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [CIW-1:0]      col_idx_q, col_idx_d;
  logic [RIW-1:0]      row_idx_q, row_idx_d;
  logic [NUM_COLS-1:0] col_q, col_d;
  scan_state_e         state_q, state_d;
  logic [NUM_KEYS-1:0] keys_down_q, keys_down_d;
  logic [CW-1:0]       cnt_q [NUM_KEYS];
  logic [CW-1:0]       cnt_d [NUM_KEYS];
  logic                overflow_q, overflow_d;

  logic                slot_end;
  logic [KEY_W-1:0]    key_idx;
  logic                raw;
  logic                ev_push;
  logic [EV_W-1:0]     ev_din, fifo_dout;
  logic                fifo_full, fifo_empty, fifo_pop;

  assign slot_end = (timer_q == TW'(SCAN_INTERVAL - 1));
  assign key_idx  = KEY_W'(row_idx_q) * KEY_W'(NUM_COLS) + KEY_W'(col_idx_q);
  assign raw      = ~row_capt_q[row_idx_q];

  // Scan FSM: the timer free-runs over the slot, the state only picks where we are in it.
  always_comb begin
    state_d    = state_q;
    row_idx_d  = row_idx_q;
    row_capt_d = row_capt_q;
    col_idx_d  = col_idx_q;
    timer_d    = slot_end ? '0 : timer_q + 1'b1;
    case (state_q)
      ST_SETTLE: begin
        if (timer_q == TW'(SAMPLE_DELAY)) begin
          row_capt_d = row_s2_q;
          row_idx_d  = '0;
          state_d    = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (row_idx_q == RIW'(NUM_ROWS - 1)) state_d = ST_WAIT;
        else                                 row_idx_d = row_idx_q + 1'b1;
      end
      ST_WAIT: begin
        if (slot_end) begin
          col_idx_d = (col_idx_q == CIW'(NUM_COLS - 1)) ? '0 : col_idx_q + 1'b1;
          state_d   = ST_SETTLE;
        end
      end
      default: state_d = ST_SETTLE;
    endcase
    for (int c = 0; c < NUM_COLS; c++) col_d[c] = (col_idx_d != CIW'(c));
  end

  // Debounce one key per SAMPLE cycle; a flip is committed even when its event is dropped.
  always_comb begin
    keys_down_d = keys_down_q;
    cnt_d       = cnt_q;
    ev_push     = 1'b0;
    ev_din      = '0;
    if (state_q == ST_SAMPLE) begin
      if (raw == keys_down_q[key_idx]) begin
        cnt_d[key_idx] = '0;
      end else if (cnt_q[key_idx] == CW'(DEBOUNCE_SCANS - 1)) begin
        keys_down_d[key_idx] = raw;
        cnt_d[key_idx]       = '0;
        ev_push              = 1'b1;
        ev_din               = {~raw, key_idx};
      end else begin
        cnt_d[key_idx] = cnt_q[key_idx] + 1'b1;
      end
    end
  end

  assign fifo_pop = kif.key_ready & ~fifo_empty;

  always_comb begin
    overflow_d = overflow_q;
    if (overflow_clr)                       overflow_d = 1'b0;
    if (ev_push && fifo_full && !fifo_pop)  overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1_q    <= '1;
      row_s2_q    <= '1;
      row_capt_q  <= '1;
      timer_q     <= '0;
      col_idx_q   <= '0;
      row_idx_q   <= '0;
      col_q       <= '1;
      state_q     <= ST_SETTLE;
      keys_down_q <= '0;
      cnt_q       <= '{default: '0};
      overflow_q  <= 1'b0;
    end else begin
      row_s1_q    <= row;
      row_s2_q    <= row_s1_q;
      row_capt_q  <= row_capt_d;
      timer_q     <= timer_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      col_q       <= col_d;
      state_q     <= state_d;
      keys_down_q <= keys_down_d;
      cnt_q       <= cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ev_push),
    .din   (ev_din),
    .full  (fifo_full),
    .pop   (fifo_pop),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  // Head fields read as zero when empty so stale slots never show.
  assign kif.key_valid                    = ~fifo_empty;
  assign {kif.key_release, kif.key_code}  = fifo_empty ? '0 : fifo_dout;

  assign col       = col_q;
  assign keys_down = keys_down_q;
  assign overflow  = overflow_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (4x4, short scan slots) with a keypad matrix model.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int NR    = 4;
  localparam int NC    = 4;
  localparam int SI    = 32;
  localparam int FRAME = SI * NC;
  localparam int KW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] row;
  logic [NC-1:0] col;
  logic [15:0]   keys_down;
  logic          overflow;
  logic          overflow_clr = 1'b0;
  scan_state_e   dbg_state;
  logic [15:0]   pressed = '0;

  int total = 0;
  int bad   = 0;
  logic [KW:0] exp_q[$];

  keypad_if #(.KEY_W(KW)) kif ();

  keypad_scanner #(
    .NUM_ROWS       (NR),
    .NUM_COLS       (NC),
    .SCAN_INTERVAL  (SI),
    .SAMPLE_DELAY   (4),
    .DEBOUNCE_SCANS (3),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .row          (row),
    .col          (col),
    .kif          (kif.master),
    .keys_down    (keys_down),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row = '1;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        if (pressed[r*NC+c] && !col[c]) row[r] = 1'b0;
  end

  // ---------------- checking / driver tasks ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic align();
    int n;
    n = 0;
    while (col == 4'b1110 && n < FRAME) begin @(negedge clk); n++; end
    while (col != 4'b1110 && n < 2*FRAME) begin @(negedge clk); n++; end
    check_eq("align_bound", 32'(col == 4'b1110), 1);
  endtask

  task automatic hold(input logic [15:0] mask, input int frames);
    pressed = mask;
    repeat (frames * FRAME) @(negedge clk);
  endtask

  task automatic measure_slot(output int n, output logic [3:0] nxt);
    logic [3:0] cur;
    cur = col;
    n = 0;
    while (col == cur && n < 100) begin @(negedge clk); n++; end
    nxt = col;
  endtask

  task automatic pop_one();
    kif.key_ready = 1'b1;
    @(negedge clk);
    kif.key_ready = 1'b0;
  endtask

  // Scoreboard: compare FIFO head against expected queue, pop each, then require empty.
  task automatic drain(input string tag);
    logic [KW:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq({tag, "_valid"}, 32'(kif.key_valid), 1);
      check_eq({tag, "_code"}, 32'(kif.key_code), 32'(e[KW-1:0]));
      check_eq({tag, "_rel"}, 32'(kif.key_release), 32'(e[KW]));
      pop_one();
    end
    check_eq({tag, "_empty"}, 32'(kif.key_valid), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         n;
    logic [3:0] nxt;
    logic [3:0] seq [4];
    logic [3:0] head_code;
    seq[0] = 4'b1011; seq[1] = 4'b0111; seq[2] = 4'b1110; seq[3] = 4'b1101;
    kif.key_ready = 1'b0;

    // 1. reset values, then column walk
    repeat (3) @(negedge clk);
    check_eq("rst_col", 32'(col), 32'hf);
    check_eq("rst_valid", 32'(kif.key_valid), 0);
    check_eq("rst_code", 32'(kif.key_code), 0);
    check_eq("rst_rel", 32'(kif.key_release), 0);
    check_eq("rst_keys", 32'(keys_down), 0);
    check_eq("rst_ovf", 32'(overflow), 0);
    rst_n = 1'b1;
    n = 0;
    while (col != 4'b1110 && n < 10) begin @(negedge clk); n++; end
    check_eq("first_col", 32'(col), 32'b1110);
    measure_slot(n, nxt);
    check_eq("col_next", 32'(nxt), 32'b1101);
    for (int i = 0; i < 4; i++) begin
      measure_slot(n, nxt);
      check_eq("slot_len", n, SI);
      check_eq("slot_col", 32'(nxt), 32'(seq[i]));
    end
    check_eq("idle_valid", 32'(kif.key_valid), 0);
    check_eq("idle_keys", 32'(keys_down), 0);

    // 2. key 6 press then release
    align();
    hold(16'h0040, 3);
    check_eq("k6_down", 32'(keys_down), 32'h0040);
    exp_q.push_back({1'b0, 4'd6});
    drain("k6_press");
    align();
    hold(16'h0000, 3);
    check_eq("k6_up", 32'(keys_down), 0);
    exp_q.push_back({1'b1, 4'd6});
    drain("k6_release");

    // 3. bounce shorter than the debounce window
    align();
    hold(16'h0040, 2);
    hold(16'h0000, 3);
    check_eq("bounce_keys", 32'(keys_down), 0);
    check_eq("bounce_valid", 32'(kif.key_valid), 0);

    // 4. two keys in one column -> ascending row order
    align();
    hold(16'h2002, 3);
    check_eq("two_keys", 32'(keys_down), 32'h2002);
    exp_q.push_back({1'b0, 4'd1});
    exp_q.push_back({1'b0, 4'd13});
    drain("two_press");
    align();
    hold(16'h0000, 3);
    exp_q.push_back({1'b1, 4'd1});
    exp_q.push_back({1'b1, 4'd13});
    drain("two_release");

    // 5. overflow with consumer stalled
    align();
    hold(16'h0040, 3);
    hold(16'h0000, 3);
    hold(16'h0002, 3);
    hold(16'h0000, 3);
    check_eq("full_no_ovf", 32'(overflow), 0);
    head_code = kif.key_code;
    repeat (10) @(negedge clk);
    check_eq("stall_stable", 32'(kif.key_code), 32'(head_code));
    hold(16'h0040, 3);
    check_eq("ovf_set", 32'(overflow), 1);
    check_eq("ovf_keys", 32'(keys_down), 32'h0040);
    hold(16'h0000, 3);
    check_eq("ovf_keys_up", 32'(keys_down), 0);
    exp_q.push_back({1'b0, 4'd6});
    exp_q.push_back({1'b1, 4'd6});
    exp_q.push_back({1'b0, 4'd1});
    exp_q.push_back({1'b1, 4'd1});
    drain("ovf_drain");
    check_eq("ovf_sticky", 32'(overflow), 1);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    check_eq("ovf_clr", 32'(overflow), 0);

    // 6. reset mid-SAMPLE with an event pending
    align();
    hold(16'h0040, 3);
    check_eq("pend_valid", 32'(kif.key_valid), 1);
    n = 0;
    while (dbg_state != ST_SAMPLE && n < FRAME) begin @(negedge clk); n++; end
    check_eq("reach_sample", 32'(dbg_state), 32'(ST_SAMPLE));
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_col", 32'(col), 32'hf);
    check_eq("mid_rst_valid", 32'(kif.key_valid), 0);
    check_eq("mid_rst_code", 32'(kif.key_code), 0);
    check_eq("mid_rst_keys", 32'(keys_down), 0);
    check_eq("mid_rst_ovf", 32'(overflow), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    n = 0;
    while (col == 4'hf && n < 10) begin @(negedge clk); n++; end
    check_eq("restart_col", 32'(col), 32'b1110);
    check_eq("restart_valid", 32'(kif.key_valid), 0);
    pressed = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
